// File: rtl/lc3b_ctrl_pkg.sv
// LC-3b control unit shared types: opcodes, sequencer states, mux encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lc3b_ctrl_pkg;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LDB   = 4'b0010;
  localparam logic [3:0] OP_STB   = 4'b0011;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDW   = 4'b0110;
  localparam logic [3:0] OP_STW   = 4'b0111;
  localparam logic [3:0] OP_RTI   = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_RSV_A = 4'b1010;
  localparam logic [3:0] OP_RSV_B = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_SHF   = 4'b1101;
  localparam logic [3:0] OP_LEA   = 4'b1110;
  localparam logic [3:0] OP_TRAP  = 4'b1111;

  typedef enum logic [4:0] {
    IDLE, FETCH_A, FETCH_B, FETCH_C, DECODE, EXEC, BR, JMP, JSR_A, JSR_B,
    ADDR, ST_MDR, MEM_RD, MEM_WR, WB, TRAP_A, TRAP_B, TRAP_C, ILLEGAL, FAULT
  } state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_XOR, ALU_PASSA} alu_k_t;
  typedef enum logic [1:0] {PC_PLUS2, PC_BUS, PC_ADDER} pc_mux_t;

  // RTI and the two reserved opcodes are never implemented; XOR and SHF are build options.
  function automatic logic is_legal(input logic [3:0] op, input logic en_xor, input logic en_shf);
    case (op)
      OP_RTI, OP_RSV_A, OP_RSV_B: is_legal = 1'b0;
      OP_XOR:                     is_legal = en_xor;
      OP_SHF:                     is_legal = en_shf;
      default:                    is_legal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lc3b_mem_timer.sv
// Counts stalled memory cycles and flags when the stall budget is used up.
// Latency: timeout is a registered compare, valid in the cycle the count reaches the limit.
// Backpressure: none; counts every mem_en cycle without mem_ready, clears otherwise.
module lc3b_mem_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_en,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [TO_W-1:0] TO_VAL = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] wait_cnt;

  // Stall counter: saturates at the limit (the sequencer leaves for FAULT there)
  // and clears whenever the access completes or no access is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!mem_en || mem_ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != TO_VAL) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = (wait_cnt == TO_VAL);

endmodule

// File: rtl/lc3b_ctrl_fsm.sv
// Multi-cycle LC-3b sequencer: fetch/decode/execute/memory/writeback, Moore output decode.
// Latency: 5 cycles for single-cycle ops with zero-wait fetch; memory states add wait cycles.
// Backpressure: memory states hold until mem_ready; a stall past MEM_TIMEOUT parks in FAULT.
module lc3b_ctrl_fsm
  import lc3b_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int EN_XOR      = 1,
  parameter int EN_SHF      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_ready,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_pc,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        gate_pc,
  output logic        gate_alu,
  output logic        gate_mdr,
  output logic        gate_marmux,
  output logic        gate_shf,
  output logic [1:0]  pc_mux,
  output logic        addr_mux,
  output logic        mar_mux,
  output logic        sr2_mux,
  output logic        dr_r7,
  output logic [1:0]  alu_k,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_byte,
  output logic        illegal_op,
  output logic        fault,
  output logic        retire
);

  state_t     state, next_state;
  logic       timeout;
  logic [3:0] op;
  logic       legal, is_store, is_byte;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign legal     = is_legal(op, EN_XOR != 0, EN_SHF != 0);
  assign is_store  = (op == OP_STW) || (op == OP_STB);
  assign is_byte   = (op == OP_LDB) || (op == OP_STB);
  assign unused_ir = ^{ir[8:6], ir[4:0]};

  lc3b_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // State register; reset lands in IDLE immediately, even mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state selection and Moore output decode of the current state.
  always_comb begin
    next_state  = state;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_ir       = 1'b0;
    ld_pc       = 1'b0;
    ld_reg      = 1'b0;
    ld_cc       = 1'b0;
    gate_pc     = 1'b0;
    gate_alu    = 1'b0;
    gate_mdr    = 1'b0;
    gate_marmux = 1'b0;
    gate_shf    = 1'b0;
    pc_mux      = PC_PLUS2;
    addr_mux    = 1'b0;
    mar_mux     = 1'b0;
    sr2_mux     = 1'b0;
    dr_r7       = 1'b0;
    alu_k       = ALU_ADD;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_byte    = 1'b0;
    illegal_op  = 1'b0;
    fault       = 1'b0;
    retire      = 1'b0;

    case (state)
      IDLE: next_state = FETCH_A;
      FETCH_A: begin
        ld_mar = 1'b1; gate_pc = 1'b1; ld_pc = 1'b1; pc_mux = PC_PLUS2;
        next_state = FETCH_B;
      end
      FETCH_B: begin
        mem_en = 1'b1; ld_mdr = mem_ready;
        if (mem_ready)    next_state = FETCH_C;
        else if (timeout) next_state = FAULT;
      end
      FETCH_C: begin
        gate_mdr = 1'b1; ld_ir = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        if (!legal) next_state = ILLEGAL;
        else begin
          case (op)
            OP_ADD, OP_AND, OP_XOR, OP_SHF, OP_LEA: next_state = EXEC;
            OP_BR:                                  next_state = BR;
            OP_JMP:                                 next_state = JMP;
            OP_JSR:                                 next_state = JSR_A;
            OP_LDW, OP_LDB, OP_STW, OP_STB:         next_state = ADDR;
            OP_TRAP:                                next_state = TRAP_A;
            default:                                next_state = ILLEGAL;
          endcase
        end
      end
      EXEC: begin
        ld_reg = 1'b1; ld_cc = (op != OP_LEA); sr2_mux = ir[5]; retire = 1'b1;
        if (op == OP_SHF)      gate_shf = 1'b1;
        else if (op == OP_LEA) gate_marmux = 1'b1;
        else                   gate_alu = 1'b1;
        if (op == OP_AND)      alu_k = ALU_AND;
        else if (op == OP_XOR) alu_k = ALU_XOR;
        next_state = FETCH_A;
      end
      BR: begin
        pc_mux = PC_ADDER; ld_pc = |(ir[11:9] & nzp); retire = 1'b1;
        next_state = FETCH_A;
      end
      JMP: begin
        pc_mux = PC_BUS; ld_pc = 1'b1; retire = 1'b1;
        next_state = FETCH_A;
      end
      JSR_A: begin
        gate_pc = 1'b1; dr_r7 = 1'b1; ld_reg = 1'b1;
        next_state = JSR_B;
      end
      JSR_B: begin
        ld_pc = 1'b1; pc_mux = ir[11] ? PC_ADDER : PC_BUS; retire = 1'b1;
        next_state = FETCH_A;
      end
      ADDR: begin
        // Base register + offset forms the effective address.
        ld_mar = 1'b1; gate_marmux = 1'b1; addr_mux = 1'b1;
        next_state = is_store ? ST_MDR : MEM_RD;
      end
      ST_MDR: begin
        // Source register passes through the ALU onto the bus into MDR.
        ld_mdr = 1'b1; gate_alu = 1'b1; alu_k = ALU_PASSA;
        next_state = MEM_WR;
      end
      MEM_RD: begin
        mem_en = 1'b1; ld_mdr = mem_ready; mem_byte = is_byte;
        if (mem_ready)    next_state = (op == OP_TRAP) ? TRAP_C : WB;
        else if (timeout) next_state = FAULT;
      end
      MEM_WR: begin
        mem_en = 1'b1; mem_we = 1'b1; mem_byte = is_byte; retire = mem_ready;
        if (mem_ready)    next_state = FETCH_A;
        else if (timeout) next_state = FAULT;
      end
      WB: begin
        gate_mdr = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; retire = 1'b1;
        next_state = FETCH_A;
      end
      TRAP_A: begin
        ld_mar = 1'b1; mar_mux = 1'b1;
        next_state = TRAP_B;
      end
      TRAP_B: begin
        dr_r7 = 1'b1; ld_reg = 1'b1; gate_pc = 1'b1;
        next_state = MEM_RD;
      end
      TRAP_C: begin
        gate_mdr = 1'b1; ld_pc = 1'b1; pc_mux = PC_BUS; retire = 1'b1;
        next_state = FETCH_A;
      end
      ILLEGAL: begin
        illegal_op = 1'b1;
        next_state = FETCH_A;
      end
      FAULT: begin
        fault = 1'b1;
        next_state = FAULT;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lc3b_ctrl_fsm.sv
// Bench for lc3b_ctrl_fsm: directed vector table, directed multi-cycle sequences, random scoreboard.
// Latency: n/a.
// Backpressure: mem_ready delays are chosen per memory phase by the bench.
module tb_lc3b_ctrl_fsm;

  localparam int TO = 15;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
    logic       gate_pc, gate_alu, gate_mdr, gate_marmux, gate_shf;
    logic [1:0] pc_mux;
    logic       addr_mux, mar_mux, sr2_mux, dr_r7;
    logic [1:0] alu_k;
    logic       mem_en, mem_we, mem_byte, illegal_op, fault, retire;
  } outs_t;

  typedef struct {
    logic  rdy;
    outs_t exp;
    outs_t care;
  } ent_t;

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    outs_t       exp;
    bit          chk_alu;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready;
  logic [15:0] ir;
  logic [2:0]  nzp;
  wire outs_t  o0;
  wire outs_t  o1;

  int    checks = 0;
  int    errors = 0;
  ent_t  q0[$];
  ent_t  q1[$];
  int    kpos;
  bit [31:0] noise;
  outs_t care_def;
  outs_t snap0, snap1, last0;
  int    cnt_mem_en, cnt_ld_mdr, cnt_we, cnt_byte, cnt_retire, cnt_fault;
  vec_t  tbl[15];

  always #5 clk = ~clk;

  lc3b_ctrl_fsm dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp(nzp), .mem_ready(mem_ready),
    .ld_mar(o0.ld_mar), .ld_mdr(o0.ld_mdr), .ld_ir(o0.ld_ir), .ld_pc(o0.ld_pc),
    .ld_reg(o0.ld_reg), .ld_cc(o0.ld_cc), .gate_pc(o0.gate_pc), .gate_alu(o0.gate_alu),
    .gate_mdr(o0.gate_mdr), .gate_marmux(o0.gate_marmux), .gate_shf(o0.gate_shf),
    .pc_mux(o0.pc_mux), .addr_mux(o0.addr_mux), .mar_mux(o0.mar_mux), .sr2_mux(o0.sr2_mux),
    .dr_r7(o0.dr_r7), .alu_k(o0.alu_k), .mem_en(o0.mem_en), .mem_we(o0.mem_we),
    .mem_byte(o0.mem_byte), .illegal_op(o0.illegal_op), .fault(o0.fault), .retire(o0.retire)
  );

  lc3b_ctrl_fsm #(.EN_XOR(0), .EN_SHF(0)) dut_nx (
    .clk(clk), .rst(rst), .ir(ir), .nzp(nzp), .mem_ready(mem_ready),
    .ld_mar(o1.ld_mar), .ld_mdr(o1.ld_mdr), .ld_ir(o1.ld_ir), .ld_pc(o1.ld_pc),
    .ld_reg(o1.ld_reg), .ld_cc(o1.ld_cc), .gate_pc(o1.gate_pc), .gate_alu(o1.gate_alu),
    .gate_mdr(o1.gate_mdr), .gate_marmux(o1.gate_marmux), .gate_shf(o1.gate_shf),
    .pc_mux(o1.pc_mux), .addr_mux(o1.addr_mux), .mar_mux(o1.mar_mux), .sr2_mux(o1.sr2_mux),
    .dr_r7(o1.dr_r7), .alu_k(o1.alu_k), .mem_en(o1.mem_en), .mem_we(o1.mem_we),
    .mem_byte(o1.mem_byte), .illegal_op(o1.illegal_op), .fault(o1.fault), .retire(o1.retire)
  );

  task automatic chk(input string nm, input outs_t act, input outs_t exp, input outs_t care);
    checks++;
    if ((act & care) !== (exp & care)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h) at %0t", nm, act, exp, care, $time);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One expected cycle; non-memory cycles drive pseudo-random mem_ready (must be ignored).
  task automatic push(input int which, input bit mem, input logic rdy, input outs_t e, input outs_t c);
    ent_t en;
    en.rdy  = mem ? rdy : noise[kpos % 32];
    en.exp  = e;
    en.care = c;
    kpos++;
    if (which == 0) q0.push_back(en);
    else            q1.push_back(en);
  endtask

  // A memory access that sees mem_ready after d stalled cycles, or faults if d exceeds the budget.
  task automatic mem_phase(input int which, input int d, input bit rd, input bit byt, output bit flt);
    outs_t e;
    int n;
    flt = (d > TO);
    n = flt ? TO + 1 : d;
    for (int i = 0; i < n; i++) begin
      e = '0; e.mem_en = 1; e.mem_we = !rd; e.mem_byte = byt;
      push(which, 1, 1'b0, e, care_def);
    end
    if (flt) begin
      for (int i = 0; i < 4; i++) begin
        e = '0; e.fault = 1;
        push(which, 0, 1'b0, e, care_def);
      end
    end else begin
      e = '0; e.mem_en = 1; e.mem_we = !rd; e.mem_byte = byt; e.ld_mdr = rd; e.retire = !rd;
      push(which, 1, 1'b1, e, care_def);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from its opcode's micro-steps.
  task automatic model(input int which, input logic [15:0] iv, input logic [2:0] nv,
                       input int df, input int dm, output bit flt);
    outs_t e, c;
    logic [3:0] op;
    bit opt_ok, byt;
    op = iv[15:12];
    opt_ok = (which == 0);
    kpos = 0;
    e = '0; e.ld_mar = 1; e.gate_pc = 1; e.ld_pc = 1;
    push(which, 0, 1'b0, e, care_def);
    mem_phase(which, df, 1, 0, flt);
    if (flt) return;
    e = '0; e.gate_mdr = 1; e.ld_ir = 1;
    push(which, 0, 1'b0, e, care_def);
    e = '0;
    push(which, 0, 1'b0, e, care_def);
    e = '0; c = care_def;
    case (op)
      4'h1, 4'h5, 4'h9, 4'hD, 4'hE: begin
        if ((op == 4'h9 || op == 4'hD) && !opt_ok) begin
          e.illegal_op = 1;
        end else begin
          e.ld_reg = 1; e.ld_cc = (op != 4'hE); e.sr2_mux = iv[5]; e.retire = 1;
          if (op == 4'hD)      e.gate_shf = 1;
          else if (op == 4'hE) e.gate_marmux = 1;
          else begin
            e.gate_alu = 1; c.alu_k = 2'b11;
            e.alu_k = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
          end
        end
        push(which, 0, 1'b0, e, c);
      end
      4'h0: begin
        e.pc_mux = 2; e.ld_pc = |(iv[11:9] & nv); e.retire = 1;
        push(which, 0, 1'b0, e, c);
      end
      4'hC: begin
        e.pc_mux = 1; e.ld_pc = 1; e.retire = 1;
        push(which, 0, 1'b0, e, c);
      end
      4'h4: begin
        e.dr_r7 = 1; e.ld_reg = 1; e.gate_pc = 1;
        push(which, 0, 1'b0, e, c);
        e = '0; e.ld_pc = 1; e.pc_mux = iv[11] ? 2'd2 : 2'd1; e.retire = 1;
        push(which, 0, 1'b0, e, c);
      end
      4'h2, 4'h3, 4'h6, 4'h7: begin
        byt = (op == 4'h2 || op == 4'h3);
        e.ld_mar = 1; e.gate_marmux = 1;
        push(which, 0, 1'b0, e, c);
        if (op == 4'h3 || op == 4'h7) begin
          e = '0; e.ld_mdr = 1; c.gate_alu = 0;
          push(which, 0, 1'b0, e, c);
          mem_phase(which, dm, 0, byt, flt);
        end else begin
          mem_phase(which, dm, 1, byt, flt);
          if (!flt) begin
            e = '0; e.gate_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; e.retire = 1;
            push(which, 0, 1'b0, e, care_def);
          end
        end
      end
      4'hF: begin
        e.ld_mar = 1; e.mar_mux = 1;
        push(which, 0, 1'b0, e, c);
        e = '0; e.dr_r7 = 1; e.ld_reg = 1; e.gate_pc = 1;
        push(which, 0, 1'b0, e, c);
        mem_phase(which, dm, 1, 0, flt);
        if (!flt) begin
          e = '0; e.gate_mdr = 1; e.ld_pc = 1; e.pc_mux = 1; e.retire = 1;
          push(which, 0, 1'b0, e, care_def);
        end
      end
      default: begin
        e.illegal_op = 1;
        push(which, 0, 1'b0, e, c);
      end
    endcase
  endtask

  // Play both expectation queues against the two DUTs, one cycle per entry.
  task automatic run_q(input int snap_at);
    ent_t e0, e1;
    int k;
    k = 0;
    cnt_mem_en = 0; cnt_ld_mdr = 0; cnt_we = 0; cnt_byte = 0; cnt_retire = 0; cnt_fault = 0;
    while (q0.size() > 0 && q1.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      @(negedge clk);
      mem_ready = e0.rdy;
      #1;
      chk("dut_cycle", o0, e0.exp, e0.care);
      chk("dut_nx_cycle", o1, e1.exp, e1.care);
      if (k == snap_at) begin snap0 = o0; snap1 = o1; end
      cnt_mem_en += int'(o0.mem_en); cnt_ld_mdr += int'(o0.ld_mdr); cnt_we += int'(o0.mem_we);
      cnt_byte += int'(o0.mem_byte); cnt_retire += int'(o0.retire); cnt_fault += int'(o0.fault);
      last0 = o0;
      k++;
    end
  endtask

  // Assert rst mid-cycle, check outputs clear at once, release; the next cycle must be IDLE.
  task automatic do_reset();
    outs_t z;
    z = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_dut", o0, z, '1);
    chk("rst_async_dut_nx", o1, z, '1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    kpos = 0; push(0, 0, 1'b0, z, '1);
    kpos = 0; push(1, 0, 1'b0, z, '1);
  endtask

  task automatic run_instr(input logic [15:0] iv, input logic [2:0] nv, input int df,
                           input int dm, input int snap_at, output bit flt);
    bit f1;
    ir = iv; nzp = nv; noise = $urandom;
    model(0, iv, nv, df, dm, flt);
    model(1, iv, nv, df, dm, f1);
    run_q(snap_at);
    if (flt) begin
      do_reset();
      run_q(-1);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return 0;
    if (r < 90) return $urandom_range(1, 4);
    if (r < 96) return TO;
    return TO + 1;
  endfunction

  function automatic vec_t mkv(input logic [15:0] iv, input logic [2:0] nv, input string nm);
    vec_t v;
    v.ir = iv; v.nzp = nv; v.exp = '0; v.chk_alu = 0; v.name = nm;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit flt;
    int n, guard;
    outs_t c;

    care_def = '1; care_def.addr_mux = 0; care_def.alu_k = 2'b00;

    tbl[0]  = mkv(16'h1261, 3'b000, "exec_add");
    tbl[0].exp.ld_reg = 1; tbl[0].exp.ld_cc = 1; tbl[0].exp.gate_alu = 1; tbl[0].exp.sr2_mux = 1;
    tbl[0].exp.retire = 1; tbl[0].exp.alu_k = 2'd0; tbl[0].chk_alu = 1;
    tbl[1]  = mkv(16'h5001, 3'b000, "exec_and");
    tbl[1].exp.ld_reg = 1; tbl[1].exp.ld_cc = 1; tbl[1].exp.gate_alu = 1;
    tbl[1].exp.retire = 1; tbl[1].exp.alu_k = 2'd1; tbl[1].chk_alu = 1;
    tbl[2]  = mkv(16'h9000, 3'b000, "exec_xor");
    tbl[2].exp.ld_reg = 1; tbl[2].exp.ld_cc = 1; tbl[2].exp.gate_alu = 1;
    tbl[2].exp.retire = 1; tbl[2].exp.alu_k = 2'd2; tbl[2].chk_alu = 1;
    tbl[3]  = mkv(16'hD020, 3'b000, "exec_shf");
    tbl[3].exp.ld_reg = 1; tbl[3].exp.ld_cc = 1; tbl[3].exp.gate_shf = 1; tbl[3].exp.sr2_mux = 1;
    tbl[3].exp.retire = 1;
    tbl[4]  = mkv(16'hE1FF, 3'b000, "exec_lea");
    tbl[4].exp.ld_reg = 1; tbl[4].exp.gate_marmux = 1; tbl[4].exp.sr2_mux = 1; tbl[4].exp.retire = 1;
    tbl[5]  = mkv(16'h0402, 3'b010, "brz_taken");
    tbl[5].exp.pc_mux = 2; tbl[5].exp.ld_pc = 1; tbl[5].exp.retire = 1;
    tbl[6]  = mkv(16'h0402, 3'b100, "brz_not_taken");
    tbl[6].exp.pc_mux = 2; tbl[6].exp.retire = 1;
    tbl[7]  = mkv(16'h0000, 3'b111, "br_never");
    tbl[7].exp.pc_mux = 2; tbl[7].exp.retire = 1;
    tbl[8]  = mkv(16'hC1C0, 3'b000, "jmp");
    tbl[8].exp.pc_mux = 1; tbl[8].exp.ld_pc = 1; tbl[8].exp.retire = 1;
    tbl[9]  = mkv(16'h4800, 3'b000, "jsr_a");
    tbl[9].exp.dr_r7 = 1; tbl[9].exp.ld_reg = 1; tbl[9].exp.gate_pc = 1;
    tbl[10] = mkv(16'h6042, 3'b000, "ldw_addr");
    tbl[10].exp.ld_mar = 1; tbl[10].exp.gate_marmux = 1;
    tbl[11] = mkv(16'hF025, 3'b000, "trap_a");
    tbl[11].exp.ld_mar = 1; tbl[11].exp.mar_mux = 1;
    tbl[12] = mkv(16'h8000, 3'b000, "illegal_8");
    tbl[12].exp.illegal_op = 1;
    tbl[13] = mkv(16'hA000, 3'b000, "illegal_a");
    tbl[13].exp.illegal_op = 1;
    tbl[14] = mkv(16'hB000, 3'b000, "illegal_b");
    tbl[14].exp.illegal_op = 1;

    rst = 1'b1; mem_ready = 1'b0; ir = '0; nzp = '0;
    repeat (2) @(posedge clk);
    do_reset();
    run_q(-1);

    // Directed table: the first post-decode cycle of each instruction.
    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i].ir, tbl[i].nzp, 0, 0, 4, flt);
      c = care_def;
      if (tbl[i].chk_alu) c.alu_k = 2'b11;
      chk(tbl[i].name, snap0, tbl[i].exp, c);
      if (tbl[i].ir[15:12] == 4'h9 || tbl[i].ir[15:12] == 4'hD) begin
        chkint({tbl[i].name, "_disabled_illegal"}, int'(snap1.illegal_op), 1);
        chkint({tbl[i].name, "_disabled_no_ld_reg"}, int'(snap1.ld_reg), 0);
      end
    end

    // LDW with three stalled cycles in the read.
    run_instr(16'h6042, 3'b000, 0, 3, -1, flt);
    chkint("ldw_mem_en_cycles", cnt_mem_en, 1 + 4);
    chkint("ldw_ld_mdr_cycles", cnt_ld_mdr, 2);
    chkint("ldw_fault", cnt_fault, 0);
    chkint("ldw_retire", cnt_retire, 1);

    // STB: byte write, retire on the exit cycle of the write.
    run_instr(16'h3042, 3'b000, 0, 2, -1, flt);
    chkint("stb_we_cycles", cnt_we, 3);
    chkint("stb_byte_cycles", cnt_byte, 3);
    chkint("stb_retire_count", cnt_retire, 1);
    chkint("stb_retire_last", int'(last0.retire), 1);

    // mem_ready arriving exactly when the stall count hits the limit is a success.
    run_instr(16'h1261, 3'b000, TO, 0, -1, flt);
    chkint("edge_mem_en_cycles", cnt_mem_en, TO + 1);
    chkint("edge_no_fault", cnt_fault, 0);
    chkint("edge_retire", cnt_retire, 1);

    // Random instructions and stall lengths against the scoreboard.
    for (int i = 0; i < 250; i++) begin
      run_instr(16'($urandom), 3'($urandom), pick_delay(), pick_delay(), -1, flt);
    end

    // Fetch stalled forever: count mem_en cycles until fault, then check it is sticky.
    ir = 16'h1261; n = 0; guard = 0;
    while (guard < 60) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (o0.fault) break;
      if (o0.mem_en) n++;
      guard++;
    end
    chkint("fault_raised", int'(o0.fault), 1);
    chkint("fault_wait_cycles", n, TO + 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #1;
      chkint("fault_sticky", int'(o0.fault), 1);
      chkint("fault_sticky_mem_en", int'(o0.mem_en), 0);
    end
    do_reset();
    run_q(-1);

    // Reset in the middle of a stalled fetch.
    guard = 0;
    while (guard < 10) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (o0.mem_en) break;
      guard++;
    end
    chkint("midaccess_mem_en_seen", int'(o0.mem_en), 1);
    repeat (3) @(negedge clk);
    do_reset();
    run_q(-1);

    run_instr(16'h1261, 3'b000, 0, 0, -1, flt);
    chkint("recovery_retire", cnt_retire, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
